lfsr_rng_bank: RTL

//  Parametrised multi-channel Galois LFSR random source with per-channel reseed, zero-lockup guard
//  and a registered valid/ready output stage. Replaces the single fixed-width generator feeding the

---
 rtl/lfsr_rng_bank_if.sv | 14 +
 rtl/lfsr_rng_bank.sv | 94 +++++++++
 2 files changed

// File: rtl/lfsr_rng_bank_if.sv
// Valid/ready stream carrying one word from every LFSR channel per transfer.
// Latency: n/a (wires only).
// Backpressure: the producer holds valid and data stable while ready is low.
// Ports: valid (master->slave), data (master->slave), ready (slave->master).
interface lfsr_rng_bank_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lfsr_rng_bank.sv
// Bank of CHANNELS Galois LFSRs with per-channel reseed, zero-seed guard and a registered output word.
// Latency: first enabled cycle after reset loads the output register; the word is valid on the next cycle.
// Backpressure: word and valid hold while ready is low; free-run mode keeps stepping, so unread states are lost.
// Ports: clk, rst (sync, active-high), en (global freeze), mode (0 free-run, 1 on-demand),
//        seed_load/seed_ch/seed_data (reseed one channel), rnd (master stream), lockup_err (zero-seed pulse).
module lfsr_rng_bank #(
  parameter int              WIDTH     = 64,
  parameter int              CHANNELS  = 4,
  parameter int              OUT_W     = 16,
  parameter logic [WIDTH-1:0] TAPS     = 64'hD800000000000000,
  parameter logic [WIDTH-1:0] SEED_BASE = 64'h1,
  localparam int             CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [CH_W-1:0]  seed_ch,
  input  logic [WIDTH-1:0] seed_data,
  lfsr_rng_bank_if.master  rnd,
  output logic             lockup_err
);

  // One extra bit so the channel count itself is representable for the range check.
  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CHANNELS);

  logic [WIDTH-1:0]          state_q [CHANNELS];
  logic [WIDTH-1:0]          state_d [CHANNELS];
  logic [CHANNELS*OUT_W-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      lockup_q, lockup_d;

  logic load;
  logic seed_hit;
  logic seed_zero;

  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  always_comb begin
    load      = en & (~valid_q | rnd.ready);
    seed_hit  = en & seed_load & ({1'b0, seed_ch} < CH_LIM);
    seed_zero = (seed_data == '0);

    data_d   = data_q;
    valid_d  = valid_q;
    lockup_d = seed_hit & seed_zero;

    // The output word always captures the pre-step state of each channel.
    if (load) begin
      valid_d = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        data_d[i*OUT_W +: OUT_W] = state_q[i][OUT_W-1:0];
      end
    end

    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      if (en && (!mode || load)) begin
        state_d[i] = galois_step(state_q[i]);
      end
      // A reseed replaces this cycle's step; a zero seed would lock the LFSR, so fall back to the reset seed.
      if (seed_hit && (seed_ch == CH_W'(i))) begin
        state_d[i] = seed_zero ? (SEED_BASE + WIDTH'(i)) : seed_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= SEED_BASE + WIDTH'(i);
      end
      data_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
      end
      data_q   <= data_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
    end
  end

  // Gating with en lets a frozen bank drop valid without losing the held word.
  assign rnd.valid  = valid_q & en;
  assign rnd.data   = data_q;
  assign lockup_err = lockup_q & en;

endmodule
